mem_access_stage: RTL and testbench

//  MEM stage of the five-stage pipeline: takes EX results, performs load/store on data-memory bus (req/ack).

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/lsu_data_align.sv | 55 +++++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 access codes, control-bit indices,
// FSM states and the access-size decode used by load/store alignment.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ex_ctrl = {mem_read,mem_write,mem_to_reg,jal,jalr,branch,reg_write}
  localparam int unsigned CTRL_MEM_READ   = 6;
  localparam int unsigned CTRL_MEM_WRITE  = 5;
  localparam int unsigned CTRL_MEM_TO_REG = 4;
  localparam int unsigned CTRL_REG_WRITE  = 0;

  // wb_ctrl = {mem_to_reg,jal,jalr,branch,reg_write,misalign}
  localparam int unsigned WB_REG_WRITE = 1;
  localparam int unsigned WB_MISALIGN  = 0;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  // Undefined funct3 codes fall through to a word access.
  function automatic acc_size_t access_size(input logic [2:0] f3, input logic is_store);
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SZ_BYTE;
    if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane logic: store byte enables / lane replication, load
// extraction with sign/zero extension. Misalign detection under MEM_MISALIGN_TRAP_EN.
module lsu_data_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  acc_size_t   size;
  logic        sext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size       = access_size(funct3, is_store);
    sext       = !funct3[2];
    byte_v     = rdata[{addr_lo, 3'b000} +: 8];
    half_v     = rdata[{addr_lo[1], 4'b0000} +: 16];
    be         = 4'hF;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {(XLEN/8){store_data[7:0]}};
        load_data = {{(XLEN-8){sext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {(XLEN/16){store_data[15:0]}};
        load_data = {{(XLEN-16){sext & half_v[15]}}, half_v};
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = addr_lo[0];
`endif
      end
      default: begin
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = |addr_lo;
`endif
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory req/ack transactions and loads the MEM/WB
// register. Optional misaligned-access trap via MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [2:0]      ex_funct3,
  input  logic [6:0]      ex_ctrl,
  input  logic [4:0]      ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_load_data,
  output logic [XLEN-1:0] wb_alu_out,
  output logic [XLEN-1:0] wb_pc,
  output logic [XLEN-1:0] wb_imm,
  output logic [5:0]      wb_ctrl,
  output logic [4:0]      wb_rd
);

  state_t          state, state_nxt;
  logic            accept, is_mem, go_busy;
  logic [2:0]      cap_f3;
  logic [1:0]      cap_lo;
  logic            cap_read;
  logic [XLEN-1:0] cap_alu, cap_pc, cap_imm;
  logic [4:0]      cap_ctrl;
  logic [4:0]      cap_rd;
  logic            killed;

  logic [2:0]      al_f3;
  logic [1:0]      al_lo;
  logic            al_store;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_load;
  logic            al_mis;

  assign ex_ready = (state == IDLE);

  // The aligner sees the incoming instruction while idle and the captured one while busy.
  always_comb begin
    al_f3    = ex_funct3;
    al_lo    = ex_alu_out[1:0];
    al_store = ex_ctrl[CTRL_MEM_WRITE];
    if (state == BUSY) begin
      al_f3    = cap_f3;
      al_lo    = cap_lo;
      al_store = dmem_we;
    end
  end

  lsu_data_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_f3),
    .is_store   (al_store),
    .addr_lo    (al_lo),
    .store_data (ex_store_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  always_comb begin
    accept    = ex_valid && !flush && (state == IDLE);
    is_mem    = ex_ctrl[CTRL_MEM_READ] | ex_ctrl[CTRL_MEM_WRITE];
    go_busy   = accept && is_mem && !al_mis;
    state_nxt = state;
    case (state)
      IDLE:    if (go_busy) state_nxt = BUSY;
      BUSY:    if (dmem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      cap_f3       <= '0;
      cap_lo       <= '0;
      cap_read     <= 1'b0;
      cap_alu      <= '0;
      cap_pc       <= '0;
      cap_imm      <= '0;
      cap_ctrl     <= '0;
      cap_rd       <= '0;
      killed       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_load_data <= '0;
      wb_alu_out   <= '0;
      wb_pc        <= '0;
      wb_imm       <= '0;
      wb_ctrl      <= '0;
      wb_rd        <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE) begin
        if (go_busy) begin
          dmem_req   <= 1'b1;
          dmem_we    <= ex_ctrl[CTRL_MEM_WRITE];
          dmem_addr  <= {ex_alu_out[XLEN-1:2], 2'b00};
          dmem_be    <= al_be;
          dmem_wdata <= al_wdata;
          cap_f3     <= ex_funct3;
          cap_lo     <= ex_alu_out[1:0];
          cap_read   <= ex_ctrl[CTRL_MEM_READ];
          cap_alu    <= ex_alu_out;
          cap_pc     <= ex_pc;
          cap_imm    <= ex_imm;
          cap_ctrl   <= ex_ctrl[CTRL_MEM_TO_REG:CTRL_REG_WRITE];
          cap_rd     <= ex_rd;
          killed     <= 1'b0;
        end else if (accept) begin
          // Non-memory op, or a trapped misaligned access: retire next edge.
          wb_valid     <= 1'b1;
          wb_load_data <= '0;
          wb_alu_out   <= ex_alu_out;
          wb_pc        <= ex_pc;
          wb_imm       <= ex_imm;
          wb_rd        <= ex_rd;
          wb_ctrl      <= {ex_ctrl[CTRL_MEM_TO_REG:CTRL_REG_WRITE], 1'b0};
          if (is_mem && al_mis) begin
            wb_ctrl[WB_REG_WRITE] <= 1'b0;
            wb_ctrl[WB_MISALIGN]  <= 1'b1;
          end
        end
      end else begin
        if (flush) killed <= 1'b1;
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          if (!(killed || flush)) begin
            wb_valid     <= 1'b1;
            wb_load_data <= cap_read ? al_load : '0;
            wb_alu_out   <= cap_alu;
            wb_pc        <= cap_pc;
            wb_imm       <= cap_imm;
            wb_rd        <= cap_rd;
            wb_ctrl      <= {cap_ctrl, 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cases followed by random traffic,
// with a bus responder and a WB monitor checking against a byte-lane reference model.
module tb_mem_access_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            ex_valid = 1'b0;
  logic            ex_ready;
  logic [XLEN-1:0] ex_alu_out = '0, ex_store_data = '0, ex_pc = '0, ex_imm = '0;
  logic [2:0]      ex_funct3 = '0;
  logic [6:0]      ex_ctrl = '0;
  logic [4:0]      ex_rd = '0;
  logic            dmem_req, dmem_we;
  logic [XLEN-1:0] dmem_addr, dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_ack = 1'b0;
  logic [XLEN-1:0] dmem_rdata = '0;
  logic            wb_valid;
  logic [XLEN-1:0] wb_load_data, wb_alu_out, wb_pc, wb_imm;
  logic [5:0]      wb_ctrl;
  logic [4:0]      wb_rd;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_funct3(ex_funct3), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_load_data(wb_load_data), .wb_alu_out(wb_alu_out), .wb_pc(wb_pc),
    .wb_imm(wb_imm), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd)
  );

  typedef struct {
    logic [31:0] load_data, alu, pc, imm;
    logic [5:0]  ctrl;
    logic [4:0]  rd;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    int unsigned delay;
  } bus_exp_t;

  wb_exp_t     wb_q[$];
  bus_exp_t    bus_q[$];
  int unsigned n_cmp = 0, n_bad = 0;
  bit          abandon = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: access width in bytes, naturally aligned lane offset.
  function automatic int unsigned nbytes(logic [2:0] f3, bit store);
    if (f3 == 3'd0 || (!store && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!store && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
    int unsigned n, off;
    logic [31:0] v;
    n = nbytes(f3, 1'b0);
    off = (addr % 4) / n * n;
    v = rdata >> (8 * off);
    if (n < 4) begin
      v = v % (32'd1 << (8 * n));
      if (f3 < 3'd4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    int unsigned n;
    logic [31:0] w;
    n = nbytes(f3, 1'b1);
    w = '0;
    for (int i = 0; i < 4; i++) w = w | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return w;
  endfunction

  function automatic bit model_misaligned(logic [2:0] f3, bit store, logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return (addr % nbytes(f3, store)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // kind: 0 ALU/jump, 1 load, 2 store. Called #1 after a rising edge.
  task automatic send(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] sdata, input logic [31:0] rdata,
                      input int unsigned delay, input bit fl_acc, input bit fl_busy);
    int unsigned guard, n, off;
    bit          st, mis;
    logic [4:0]  low;
    wb_exp_t     w;
    bus_exp_t    b;
    guard = 0;
    while (!ex_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ex_ready) check("ex_ready_timeout", 32'(ex_ready), 32'd1);
    st  = (kind == 2);
    low = 5'($urandom);
    ex_valid      = 1'b1;
    flush         = fl_acc;
    ex_alu_out    = addr;
    ex_store_data = sdata;
    ex_pc         = $urandom;
    ex_imm        = $urandom;
    ex_funct3     = f3;
    ex_rd         = 5'($urandom);
    ex_ctrl       = {kind == 1, kind == 2, low};
    mis = (kind != 0) && model_misaligned(f3, st, addr);
    w.load_data = '0;
    w.alu = addr; w.pc = ex_pc; w.imm = ex_imm; w.rd = ex_rd;
    w.ctrl = {low, 1'b0};
    if (mis) w.ctrl = {low[4:1], 1'b0, 1'b1};
    if (kind == 1 && !mis) w.load_data = model_load(f3, addr, rdata);
    if (!fl_acc && kind != 0 && !mis) begin
      n = nbytes(f3, st);
      off = (addr % 4) / n * n;
      b.we = st; b.addr = addr & ~32'd3; b.rdata = rdata; b.delay = delay;
      b.be = 4'(((32'd1 << n) - 1) << off);
      b.wdata = model_wdata(f3, sdata);
      bus_q.push_back(b);
    end
    if (!fl_acc && !(kind != 0 && !mis && fl_busy)) wb_q.push_back(w);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    flush    = 1'b0;
    if (!fl_acc && (kind == 0 || mis)) begin
      check("ex_ready_after_alu", 32'(ex_ready), 32'd1);
      check("no_req_for_alu", 32'(dmem_req), 32'd0);
    end else if (!fl_acc) begin
      check("ex_ready_busy", 32'(ex_ready), 32'd0);
      if (fl_busy) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
    end
  endtask

  // Bus responder: checks each request against the expected transaction, acks after delay.
  initial begin : responder
    bus_exp_t    e;
    int unsigned held;
    bit          gone;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_req) begin
        if (bus_q.size() == 0) begin
          check("unexpected_dmem_req", 32'(dmem_req), 32'd0);
          e.delay = 0; e.rdata = '0; e.addr = dmem_addr; e.we = dmem_we;
        end else begin
          e = bus_q.pop_front();
          check("dmem_addr", dmem_addr, e.addr);
          check("dmem_we", 32'(dmem_we), 32'(e.we));
          if (e.we) begin
            check("dmem_be", 32'(dmem_be), 32'(e.be));
            check("dmem_wdata", dmem_wdata, e.wdata);
          end
        end
        held = 1;
        gone = 1'b0;
        for (int unsigned d = 0; d < e.delay; d++) begin
          @(negedge clk);
          if (!dmem_req) begin
            if (!abandon) check("req_held_until_ack", 32'(dmem_req), 32'd1);
            gone = 1'b1;
            break;
          end
          held++;
        end
        if (!gone) begin
          check("dmem_addr_stable", dmem_addr, e.addr);
          dmem_ack   = 1'b1;
          dmem_rdata = e.rdata;
          @(negedge clk);
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          check("req_drop_after_ack", 32'(dmem_req), 32'd0);
          check("req_cycles", held, e.delay + 1);
        end
      end
    end
  end

  wb_exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (wb_q.size() == 0) begin
        check("spurious_wb_valid", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = wb_q.pop_front();
        check("wb_load_data", wb_load_data, mon_e.load_data);
        check("wb_alu_out", wb_alu_out, mon_e.alu);
        check("wb_pc", wb_pc, mon_e.pc);
        check("wb_imm", wb_imm, mon_e.imm);
        check("wb_ctrl", 32'(wb_ctrl), 32'(mon_e.ctrl));
        check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d expected results pending", wb_q.size());
    $fatal(1, "timeout");
  end

  initial begin : main
    int unsigned guard;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ex_ready", 32'(ex_ready), 32'd1);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_wb_load_data", wb_load_data, 32'd0);
    check("reset_wb_alu_out", wb_alu_out, 32'd0);
    check("reset_wb_ctrl", 32'(wb_ctrl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(ex_ready), 32'd1);

    send(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b0);
    send(1, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 1'b0, 1'b0);
    send(1, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 1'b0);
    send(1, 3'b101, 32'h102, 32'h0, 32'h80112233, 0, 1'b0, 1'b0);
    send(2, 3'b000, 32'h101, 32'hAB, 32'h0, 1, 1'b0, 1'b0);
    send(2, 3'b001, 32'h102, 32'h1234, 32'h0, 0, 1'b0, 1'b0);
    send(0, 3'b000, 32'h55, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    send(0, 3'b000, 32'h1000, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    send(0, 3'b000, 32'h77, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    send(1, 3'b010, 32'h104, 32'h0, 32'h12345678, 1, 1'b0, 1'b1);
    send(0, 3'b000, 32'h99, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    send(0, 3'b000, 32'h66, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    send(1, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 1, 1'b0, 1'b0);
    send(2, 3'b001, 32'h203, 32'h5A5A, 32'h0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      send($urandom_range(0, 2), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
           $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    guard = 0;
    while ((wb_q.size() != 0 || bus_q.size() != 0 || dmem_req || !ex_ready) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_wb_pending", wb_q.size(), 32'd0);
    check("drain_bus_pending", bus_q.size(), 32'd0);

    // Asynchronous reset while a load is outstanding abandons it.
    abandon = 1'b1;
    send(1, 3'b010, 32'h200, 32'h0, 32'h11111111, 8, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("req_before_async_reset", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_req", 32'(dmem_req), 32'd0);
    check("async_reset_ready", 32'(ex_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_wb_valid", 32'(wb_valid), 32'd0);
    check("post_reset_req", 32'(dmem_req), 32'd0);
    check("final_wb_pending", wb_q.size(), 32'd0);
    check("final_bus_pending", bus_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
